// File: rtl/jsv_bitmap_writer.sv
// Pixel-to-SDRAM bitmap writer: 2-stage address pipeline, write FIFO, Avalon-MM master, double-buffer flip.
// Optional macro JSV_CLIP_EN enables discarding of out-of-frame pixels with a saturating drop counter.
module jsv_bitmap_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int PIX_W      = 8,
  parameter int BUS_W      = 16,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 24'h04B000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [XW-1:0]        pix_x,
  input  logic [YW-1:0]        pix_y,
  input  logic [PIX_W-1:0]     pix_i,
  input  logic                 pix_last,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_write,
  output logic [BUS_W-1:0]     avm_writedata,
  output logic [BUS_W/8-1:0]   avm_byteenable,
  input  logic                 avm_waitrequest,
  output logic                 front_sel,
  output logic                 frame_done,
  output logic [15:0]          drop_count,
  output logic                 dbg_state
);
  // Handshakes: a pixel moves when pix_valid && pix_ready; a bus write completes
  // when avm_write && !avm_waitrequest, and the presented write holds until then.

  localparam int BE_W  = BUS_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + BUS_W + BE_W;
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic   frame_done_q, frame_done_d;

  logic              s1_valid_q, s1_drop_q;
  logic [ADDR_W-1:0] s1_ymul_q, s1_x_q, s1_base_q;
  logic [PIX_W-1:0]  s1_pix_q;

  logic              s2_valid_q, s2_drop_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [BUS_W-1:0]  s2_data_q;
  logic [BE_W-1:0]   s2_be_q;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_write_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [BUS_W-1:0]  out_data_q;
  logic [BE_W-1:0]   out_be_q;
  logic [15:0]       drop_q;

  logic              accept, clip, out_free, fifo_empty, s2_push, pop, bypass, push, drain_done;
  logic [CNT_W-1:0]  occupancy;
  logic [ADDR_W-1:0] lin, offset, addr_d;
  logic [BUS_W-1:0]  data_d;
  logic [BE_W-1:0]   be_d;
  logic [ENT_W-1:0]  head;

  assign occupancy = count_q + CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q);
  assign pix_ready = !reset_reset && (state_q == ST_RUN) && (occupancy < DEPTH_C);
  assign accept    = pix_valid && pix_ready;

`ifdef JSV_CLIP_EN
  localparam logic [31:0] H_LIM = H_RES;
  localparam logic [31:0] V_LIM = V_RES;
  assign clip = (32'(pix_x) >= H_LIM) || (32'(pix_y) >= V_LIM);
`else
  assign clip = 1'b0;
`endif

  // Stage 2 address: the row product was registered in stage 1.
  assign lin    = s1_ymul_q + s1_x_q;
  assign offset = (PIX_W == 16) ? {lin[ADDR_W-2:0], 1'b0} : lin;
  assign addr_d = s1_base_q + offset;

  generate
    if (PIX_W == 8) begin : g_pix8
      assign data_d = BUS_W'({s1_pix_q, s1_pix_q});
      assign be_d   = addr_d[0] ? BE_W'(2'b10) : BE_W'(2'b01);
    end else begin : g_pix16
      assign data_d = BUS_W'(s1_pix_q);
      assign be_d   = '1;
    end
  endgenerate

  assign out_free   = !out_write_q || !avm_waitrequest;
  assign fifo_empty = (count_q == '0);
  assign s2_push    = s2_valid_q && !s2_drop_q;
  assign pop        = out_free && !fifo_empty;
  // An empty FIFO lets stage 2 load the bus register directly; ordering is preserved.
  assign bypass     = out_free && fifo_empty && s2_push;
  assign push       = s2_push && !bypass;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head       = mem_q[rd_ptr_q];
  assign drain_done = !s1_valid_q && !s2_valid_q && fifo_empty && out_free;

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (accept && pix_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) begin
        state_d      = ST_RUN;
        front_sel_d  = !front_sel_q;
        frame_done_d = 1'b1;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= ST_RUN;
      front_sel_q  <= 1'b0;
      frame_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_drop_q    <= 1'b0;
      s1_ymul_q    <= '0;
      s1_x_q       <= '0;
      s1_base_q    <= '0;
      s1_pix_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_drop_q    <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      s2_be_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_write_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      frame_done_q <= frame_done_d;
      s1_valid_q   <= accept;
      s1_drop_q    <= clip;
      s1_ymul_q    <= ADDR_W'(pix_y) * H_RES_A;
      s1_x_q       <= ADDR_W'(pix_x);
      s1_base_q    <= front_sel_q ? '0 : BUF1_BASE;
      s1_pix_q     <= pix_i;
      s2_valid_q   <= s1_valid_q;
      s2_drop_q    <= s1_drop_q;
      s2_addr_q    <= addr_d;
      s2_data_q    <= data_d;
      s2_be_q      <= be_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (out_free) begin
        out_write_q <= pop || bypass;
        if (pop) begin
          {out_addr_q, out_data_q, out_be_q} <= head;
        end else if (bypass) begin
          out_addr_q <= s2_addr_q;
          out_data_q <= s2_data_q;
          out_be_q   <= s2_be_q;
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s2_addr_q, s2_data_q, s2_be_q};
  end

`ifdef JSV_CLIP_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) drop_q <= '0;
    else if (s2_valid_q && s2_drop_q && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end
`else
  assign drop_q = 16'h0000;
`endif

  assign avm_address    = out_addr_q;
  assign avm_write      = out_write_q;
  assign avm_writedata  = out_data_q;
  assign avm_byteenable = out_be_q;
  assign front_sel      = front_sel_q;
  assign frame_done     = frame_done_q;
  assign drop_count     = drop_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_jsv_bitmap_writer.sv
// Bench for jsv_bitmap_writer: random pixels against a frame-buffer address model and write scoreboard.
module tb_jsv_bitmap_writer;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int FIFO_DEPTH = 16;
  localparam int BUF1 = 32'h04B000;

  logic        clk, reset;
  logic        pix_valid, pix_ready, pix_last;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_i;
  logic [23:0] avm_address;
  logic        avm_write, avm_waitrequest;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        front_sel, frame_done, dbg_state;
  logic [15:0] drop_count;

  logic [41:0] exp_q[$];
  int checks = 0, errors = 0;
  int accepted = 0, writes_done = 0, fd_count = 0;
  int model_front = 0, model_drops = 0;
  bit mon_en = 0, prev_stall = 0, rand_wr = 0;
  logic [41:0] stall_snap;

  jsv_bitmap_writer dut (
    .clk_clk(clk), .reset_reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_i(pix_i), .pix_last(pix_last),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .front_sel(front_sel), .frame_done(frame_done), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_wr) avm_waitrequest = ($urandom_range(0, 3) == 0);
  end

  // Scoreboard: completed writes against the expected queue, plus hold-while-stalled.
  always @(negedge clk) begin
    logic [41:0] got, exp;
    got = {avm_address, avm_writedata, avm_byteenable};
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        if (avm_write !== 1'b1 || got !== stall_snap) begin
          errors++;
          $display("FAIL stall_hold got w=%b %h required w=1 %h", avm_write, got, stall_snap);
        end
      end
      if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
        checks++;
        writes_done++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h be=%b", avm_address, avm_writedata, avm_byteenable);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL write got addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                     got[41:18], got[17:2], got[1:0], exp[41:18], exp[17:2], exp[1:0]);
          end
        end
      end
      prev_stall = (avm_write === 1'b1) && (avm_waitrequest === 1'b1);
      stall_snap = got;
      if (frame_done === 1'b1) fd_count++;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic model_accept(input int x, input int y, input int iv);
    bit clip;
    logic [23:0] a;
    logic [7:0] v;
    clip = 0;
`ifdef JSV_CLIP_EN
    clip = (x >= H_RES) || (y >= V_RES);
`endif
    v = 8'(iv);
    if (clip) begin
      if (model_drops < 65535) model_drops++;
    end else begin
      a = 24'((model_front != 0 ? 0 : BUF1) + y * H_RES + x);
      exp_q.push_back({a, v, v, (a[0] ? 2'b10 : 2'b01)});
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_pixel(input int x, input int y, input int iv, input bit last);
    int t;
    bit ok;
    pix_valid = 1; pix_x = 10'(x); pix_y = 9'(y); pix_i = 8'(iv); pix_last = last;
    t = 0; ok = 0;
    while (!ok && t < 3000) begin
      @(negedge clk);
      if (pix_ready === 1'b1) ok = 1;
      else t++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got no pix_ready required accept of x=%0d y=%0d", x, y);
    end else begin
      model_accept(x, y, iv);
      accepted++;
    end
    @(posedge clk); #1;
    pix_valid = 0; pix_last = 0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || avm_write !== 1'b0) && t < 2000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (exp_q.size() != 0 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d required 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1; pix_valid = 0; pix_last = 0; pix_x = 0; pix_y = 0; pix_i = 0; avm_waitrequest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({avm_write, avm_address, avm_writedata, avm_byteenable, frame_done, front_sel, drop_count, pix_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got w=%b a=%h d=%h be=%b fd=%b fs=%b dc=%h rdy=%b required all 0",
               avm_write, avm_address, avm_writedata, avm_byteenable, frame_done, front_sel, drop_count, pix_ready);
    end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", pix_ready); end
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  task automatic test_single;
    int lat;
    send_pixel(5, 2, 8'h3C, 0);
    lat = 0;
    while (avm_write !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency got %0d required 3", lat); end
    checks++;
    if (avm_address !== 24'h04B505 || avm_writedata !== 16'h3C3C || avm_byteenable !== 2'b10) begin
      errors++;
      $display("FAIL single_write got %h %h %b required 04b505 3c3c 10", avm_address, avm_writedata, avm_byteenable);
    end
    wait_drain("single");
  endtask

  task automatic test_stall;
    int w0;
    w0 = writes_done;
    avm_waitrequest = 1;
    fork
      begin
        for (int n = 0; n < 20; n++)
          send_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom_range(0, 255), 0);
      end
      begin
        int t;
        t = 0;
        while (avm_write !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        @(posedge clk); #1; avm_waitrequest = 0;
      end
    join
    wait_drain("stall");
    checks++;
    if (writes_done - w0 != 20) begin errors++; $display("FAIL stall_count got %0d required 20", writes_done - w0); end
  endtask

  task automatic test_backpressure;
    bit seen_low;
    int outst;
    seen_low = 0; outst = 0;
    avm_waitrequest = 1;
    fork
      begin
        for (int n = 0; n < 30; n++)
          send_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom_range(0, 255), 0);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (pix_ready !== 1'b1 && !seen_low && avm_waitrequest) begin
            seen_low = 1; outst = accepted - writes_done;
          end
          if (c == 40) begin @(posedge clk); #1; avm_waitrequest = 0; end
        end
      end
    join
    wait_drain("backpressure");
    checks++;
    if (!seen_low || outst < FIFO_DEPTH || outst > FIFO_DEPTH + 1) begin
      errors++;
      $display("FAIL backpressure got low=%b outstanding=%0d required low=1 outstanding %0d..%0d",
               seen_low, outst, FIFO_DEPTH, FIFO_DEPTH + 1);
    end
  endtask

  task automatic end_frame(input int x, input int y, input string name);
    int fd0, t;
    bit old_fs;
    fd0 = fd_count; old_fs = front_sel; t = 0;
    send_pixel(x, y, $urandom_range(0, 255), 1);
    while (frame_done !== 1'b1 && t < 200) begin
      @(negedge clk); t++;
      if (frame_done !== 1'b1) begin
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_drain got %b required 0", name, pix_ready); end
      end
    end
    checks++;
    if (front_sel !== ~old_fs || front_sel !== ((model_front == 0) ? 1'b1 : 1'b0)) begin
      errors++; $display("FAIL %s_front_sel got %b required %b", name, front_sel, ~old_fs);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (fd_count - fd0 != 1) begin errors++; $display("FAIL %s_frame_done got %0d pulses required 1", name, fd_count - fd0); end
    model_front = (model_front == 0) ? 1 : 0;
    wait_drain(name);
  endtask

  task automatic test_frame;
    end_frame(0, 0, "frame");
    send_pixel(0, 0, 8'h5A, 0);
    wait_drain("frame_next");
  endtask

  task automatic test_reset_stall;
    int t;
    avm_waitrequest = 1;
    send_pixel(7, 3, 8'h99, 0);
    t = 0;
    while (avm_write !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    reset = 1; mon_en = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (avm_write !== 1'b0 || front_sel !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_stall got w=%b fs=%b rdy=%b required 0 0 0", avm_write, front_sel, pix_ready);
    end
    @(posedge clk); #1;
    reset = 0; avm_waitrequest = 0;
    exp_q.delete(); model_front = 0; model_drops = 0;
    mon_en = 1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_stall_ready got %b required 1", pix_ready); end
    repeat (10) @(posedge clk); #1;
    wait_drain("reset_stall");
  endtask

  task automatic test_random;
    rand_wr = 1;
    for (int n = 0; n < 40; n++) begin
      send_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom_range(0, 255), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_wr = 0;
    @(posedge clk); #2; avm_waitrequest = 0;
    wait_drain("random");
    end_frame($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), "random_frame");
    checks++;
    if (drop_count !== 16'(model_drops)) begin
      errors++; $display("FAIL random_drop got %0d required %0d", drop_count, model_drops);
    end
  endtask

  task automatic test_clip;
`ifdef JSV_CLIP_EN
    send_pixel(640, 0, 8'h11, 0);
    send_pixel(0, 480, 8'h22, 0);
    send_pixel(639, 479, 8'h33, 0);
    wait_drain("clip");
    checks++;
    if (drop_count !== 16'(model_drops)) begin
      errors++; $display("FAIL clip_drop got %0d required %0d", drop_count, model_drops);
    end
    end_frame(700, 10, "clip_last");
    checks++;
    if (drop_count !== 16'(model_drops)) begin
      errors++; $display("FAIL clip_last_drop got %0d required %0d", drop_count, model_drops);
    end
`else
    send_pixel(639, 479, 8'h33, 0);
    wait_drain("noclip");
    checks++;
    if (drop_count !== 16'h0000) begin errors++; $display("FAIL noclip_drop got %0d required 0", drop_count); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_backpressure;
    test_frame;
    test_reset_stall;
    test_clip;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
